mux16to1: RTL and testbench

- Registered 16-to-1 selector: picks one lane of a packed 16-lane input bus using a 4-bit select and drives it on a registered output.
- Sits in datapath glue wherever one bit (or narrow lane) of a 16-entry vector must be chosen per cycle.
- Built as a two-level tree of 4-to-1 selectors followed by an output register with enable and valid tracking.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux4to1.sv | 26 ++
 rtl/mux16to1.sv | 99 +++++++++
 tb/tb_mux16to1.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the 16-to-1 lane selector
//
// Purpose : lane count, select width and select type used by mux16to1 and
//           its testbench.
// Ports   : none (package)

package mux_pkg;

    localparam int NUM_LANES = 16;
    localparam int SEL_W     = 4;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/mux4to1.sv
// rtl/mux4to1.sv - combinational 4-to-1 lane selector, one node of the select tree
//
// Purpose : picks one of four packed LANE_W-bit lanes.
// Ports   : d   [4*LANE_W-1:0] packed lanes, lane 0 at the LSBs
//           sel [1:0]          lane select
//           y   [LANE_W-1:0]   selected lane

module mux4to1 #(
    parameter int LANE_W = 1
) (
    input  logic [4*LANE_W-1:0] d,
    input  logic [1:0]          sel,
    output logic [LANE_W-1:0]   y
);

    always_comb begin
        y = d[0 +: LANE_W];
        case (sel)
            2'd1:    y = d[1*LANE_W +: LANE_W];
            2'd2:    y = d[2*LANE_W +: LANE_W];
            2'd3:    y = d[3*LANE_W +: LANE_W];
            default: y = d[0 +: LANE_W];
        endcase
    end

endmodule : mux4to1

// File: rtl/mux16to1.sv
// rtl/mux16to1.sv - registered 16-to-1 lane selector with valid tracking
//
// Purpose : selects lane s of the packed bus a through a two-level tree of
//           4-to-1 selectors and registers it on y when in_valid is high.
// Ports   : clk       rising-edge clock
//           rst_n     asynchronous active-low reset
//           a         [16*LANE_W-1:0] packed lanes, lane i = a[i*LANE_W +: LANE_W]
//           s         [3:0] lane select
//           in_valid  qualifies a/s this cycle
//           y         [LANE_W-1:0] registered selected lane
//           out_valid y holds a freshly captured lane
// Options : MUX16TO1_INPUT_REG_EN adds an input register stage (latency 2).

module mux16to1
    import mux_pkg::*;
#(
    parameter int LANE_W = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_LANES*LANE_W-1:0] a,
    input  logic [SEL_W-1:0]            s,
    input  logic                        in_valid,
    output logic [LANE_W-1:0]           y,
    output logic                        out_valid
);

    // Inputs as seen by the select tree (direct or after the optional stage)
    logic [NUM_LANES*LANE_W-1:0] a_st;
    sel_t                        s_st;
    logic                        v_st;

`ifdef MUX16TO1_INPUT_REG_EN
    logic [NUM_LANES*LANE_W-1:0] a_q;
    sel_t                        s_q;
    logic                        v_q;

    // Data and select only load on valid cycles so an undriven select while
    // idle never reaches the tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            s_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                a_q <= a;
                s_q <= s;
            end
        end
    end

    assign a_st = a_q;
    assign s_st = s_q;
    assign v_st = v_q;
`else
    assign a_st = a;
    assign s_st = s;
    assign v_st = in_valid;
`endif

    // First level: four groups of four lanes, each resolved by s[1:0]
    logic [4*LANE_W-1:0] l1_lane;
    logic [LANE_W-1:0]   sel_lane;

    for (genvar g = 0; g < 4; g++) begin : g_l1
        mux4to1 #(
            .LANE_W (LANE_W)
        ) u_mux (
            .d   (a_st[g*4*LANE_W +: 4*LANE_W]),
            .sel (s_st[1:0]),
            .y   (l1_lane[g*LANE_W +: LANE_W])
        );
    end

    // Second level: pick the group with s[3:2]
    mux4to1 #(
        .LANE_W (LANE_W)
    ) u_l2 (
        .d   (l1_lane),
        .sel (s_st[3:2]),
        .y   (sel_lane)
    );

    // y holds across idle cycles; out_valid flags only freshly captured data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v_st;
            if (v_st) begin
                y <= sel_lane;
            end
        end
    end

endmodule : mux16to1

// File: tb/tb_mux16to1.sv
// tb/tb_mux16to1.sv - self-checking testbench for mux16to1

module tb_mux16to1;

`ifdef MUX16TO1_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic [3:0]  s;
    logic        in_valid;
    logic        y;
    logic        out_valid;
    logic [63:0] a4;
    logic [3:0]  y4;
    logic        out_valid4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux16to1 #(.LANE_W(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .s         (s),
        .in_valid  (in_valid),
        .y         (y),
        .out_valid (out_valid)
    );

    mux16to1 #(.LANE_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .s         (s),
        .in_valid  (in_valid),
        .y         (y4),
        .out_valid (out_valid4)
    );

    // Reference: lane k of a bus is simply the bus shifted right by k lanes.
    function automatic logic ref_lane1(input logic [15:0] bus, input logic [3:0] k);
        logic [15:0] t;
        t = (bus >> k) & 16'h1;
        return t[0];
    endfunction

    function automatic logic [3:0] ref_lane4(input logic [63:0] bus, input logic [3:0] k);
        logic [63:0] t;
        t = (bus >> (k * 4)) & 64'hF;
        return t[3:0];
    endfunction

    // Behavioural model: a LAT-deep delay line of captured transactions.
    logic       p_v  [0:1];
    logic       p_y  [0:1];
    logic [3:0] p_y4 [0:1];
    logic       m_y, m_v;
    logic [3:0] m_y4;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            p_v[i] = 1'b0; p_y[i] = 1'b0; p_y4[i] = 4'h0;
        end
        m_y = 1'b0; m_v = 1'b0; m_y4 = 4'h0;
    endtask

    task automatic model_edge();
        for (int i = LAT - 1; i > 0; i--) begin
            p_v[i] = p_v[i-1]; p_y[i] = p_y[i-1]; p_y4[i] = p_y4[i-1];
        end
        p_v[0]  = in_valid;
        p_y[0]  = in_valid ? ref_lane1(a, s) : 1'b0;
        p_y4[0] = in_valid ? ref_lane4(a4, s) : 4'h0;
        m_v = p_v[LAT-1];
        if (p_v[LAT-1]) begin
            m_y  = p_y[LAT-1];
            m_y4 = p_y4[LAT-1];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check1({tag, "_y"}, y, m_y);
        check1({tag, "_vld"}, out_valid, m_v);
        check4({tag, "_y4"}, y4, m_y4);
        check1({tag, "_vld4"}, out_valid4, m_v);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [3:0]  s;
        logic        exp_y;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [15:0] va, input logic [3:0] vs, input logic ve);
        vec_t v;
        v.a = va; v.s = vs; v.exp_y = ve;
        vecs.push_back(v);
    endtask

    initial begin
        // ---------------- vector table ----------------
        add_vec(16'h8000, 4'hF, 1'b1);
        add_vec(16'h7FFF, 4'hF, 1'b0);
        add_vec(16'h0001, 4'h0, 1'b1);
        add_vec(16'hFFFE, 4'h0, 1'b0);
        add_vec(16'hA5A5, 4'h5, 1'b1);
        add_vec(16'hA5A5, 4'h6, 1'b0);
        add_vec(16'h1234, 4'h9, 1'b1);
        add_vec(16'h1234, 4'h8, 1'b0);
        for (int k = 0; k < 16; k++) begin
            add_vec(16'hF0F0, 4'(k), ((k >= 4 && k < 8) || k >= 12) ? 1'b1 : 1'b0);
        end
        for (int k = 0; k < 16; k++) begin
            add_vec(16'h1 << k, 4'(k), 1'b1);
            add_vec(16'h1 << k, 4'((k + 1) % 16), 1'b0);
        end

        // ---------------- reset ----------------
        model_reset();
        rst_n = 1'b0; a = 16'hFFFF; s = 4'h0; in_valid = 1'b1;
        a4 = {$urandom, $urandom};
        #1;
        check1("rst_async_y", y, 1'b0);
        check1("rst_async_vld", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("rst_hold_y", y, 1'b0);
            check1("rst_hold_vld", out_valid, 1'b0);
            check4("rst_hold_y4", y4, 4'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) tick();
        check1("rst_release_y", y, 1'b1);
        check1("rst_release_vld", out_valid, 1'b1);
        check_model("rst_release");

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            a = vecs[i].a; s = vecs[i].s; in_valid = 1'b1;
            a4 = {$urandom, $urandom};
            tick();
            in_valid = 1'b0;
            a = ~vecs[i].a; s = ~vecs[i].s;
            for (int j = 1; j < LAT; j++) tick();
            check1($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
            check1($sformatf("vec%0d_vld", i), out_valid, 1'b1);
            check4($sformatf("vec%0d_y4", i), y4, m_y4);
        end

        // ---------------- hold ----------------
        a = 16'h8000; s = 4'hF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; s = 4'h0;
        for (int j = 1; j < LAT; j++) tick();
        check1("hold_cap_y", y, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("hold_y", y, 1'b1);
            check1("hold_vld", out_valid, 1'b0);
        end

        // idle with undriven select must not disturb y
        s = 4'bxxxx; a = 16'h0000;
        tick();
        check1("xsel_y", y, 1'b1);
        check1("xsel_vld", out_valid, 1'b0);

        // ---------------- back-to-back sweep with mid-stream reset ----------------
        a = 16'hF0F0; in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s = 4'(k); a4 = {$urandom, $urandom};
            tick();
            check_model("sweep");
            if (k == 7) begin
                #2 rst_n = 1'b0;
                #1;
                check1("midrst_y", y, 1'b0);
                check1("midrst_vld", out_valid, 1'b0);
                check4("midrst_y4", y4, 4'h0);
                model_reset();
                tick();
                check_model("midrst_hold");
                rst_n = 1'b1;
            end
        end
        // drain the pipeline and confirm the last lane (s=F -> 1)
        in_valid = 1'b0;
        for (int j = 1; j < LAT; j++) begin
            tick();
            check_model("sweep_drain");
        end
        check1("sweep_last_y", y, 1'b1);

        // ---------------- randomized against the model ----------------
        for (int i = 0; i < 400; i++) begin
            a  = 16'($urandom);
            a4 = {$urandom, $urandom};
            s  = 4'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                #1 model_reset();
                check_model("rand_rst");
            end else begin
                rst_n = 1'b1;
            end
            tick();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux16to1
